// File: rtl/crd_rd_arb_if.sv
// Coordinate read channel bundle: KNN and FPS requester handshakes plus the GLB read port.
// slave = arbiter view, master = requester/GLB environment view.
interface crd_rd_arb_if #(
    parameter int IDX_WIDTH  = 10,
    parameter int SRAM_WIDTH = 256
);
    logic [IDX_WIDTH-1:0]  KNNARB_CrdAddr;
    logic                  KNNARB_CrdAddrVld;
    logic                  ARBKNN_CrdAddrRdy;
    logic [SRAM_WIDTH-1:0] ARBKNN_Crd;
    logic                  ARBKNN_CrdVld;
    logic                  KNNARB_CrdRdy;

    logic [IDX_WIDTH-1:0]  FPSARB_CrdAddr;
    logic                  FPSARB_CrdAddrVld;
    logic                  ARBFPS_CrdAddrRdy;
    logic [SRAM_WIDTH-1:0] ARBFPS_Crd;
    logic                  ARBFPS_CrdVld;
    logic                  FPSARB_CrdRdy;

    logic [IDX_WIDTH-1:0]  ARBGLB_CrdAddr;
    logic                  ARBGLB_CrdAddrVld;
    logic                  GLBARB_CrdAddrRdy;
    logic [SRAM_WIDTH-1:0] GLBARB_Crd;
    logic                  GLBARB_CrdVld;
    logic                  ARBGLB_CrdRdy;

    modport slave (
        input  KNNARB_CrdAddr, KNNARB_CrdAddrVld, KNNARB_CrdRdy,
        output ARBKNN_CrdAddrRdy, ARBKNN_Crd, ARBKNN_CrdVld,
        input  FPSARB_CrdAddr, FPSARB_CrdAddrVld, FPSARB_CrdRdy,
        output ARBFPS_CrdAddrRdy, ARBFPS_Crd, ARBFPS_CrdVld,
        output ARBGLB_CrdAddr, ARBGLB_CrdAddrVld, ARBGLB_CrdRdy,
        input  GLBARB_CrdAddrRdy, GLBARB_Crd, GLBARB_CrdVld
    );

    modport master (
        output KNNARB_CrdAddr, KNNARB_CrdAddrVld, KNNARB_CrdRdy,
        input  ARBKNN_CrdAddrRdy, ARBKNN_Crd, ARBKNN_CrdVld,
        output FPSARB_CrdAddr, FPSARB_CrdAddrVld, FPSARB_CrdRdy,
        input  ARBFPS_CrdAddrRdy, ARBFPS_Crd, ARBFPS_CrdVld,
        input  ARBGLB_CrdAddr, ARBGLB_CrdAddrVld, ARBGLB_CrdRdy,
        output GLBARB_CrdAddrRdy, GLBARB_Crd, GLBARB_CrdVld
    );
endinterface

// File: rtl/crd_rd_arb.sv
// KNN/FPS arbiter for the shared GLB coordinate read port with an in-order owner tag FIFO.
// Define CRD_ARB_RR_EN for round-robin tie breaking; otherwise KNN has fixed priority.
module crd_rd_arb #(
    parameter int IDX_WIDTH  = 10,
    parameter int SRAM_WIDTH = 256,
    parameter int NUM_OUTSTD = 4
) (
    input  logic         clk,
    input  logic         rst,
    crd_rd_arb_if.slave  bus,
    output logic         ARBCCU_Idle,
    output logic         ARBCCU_Err
);
    localparam int PW = $clog2(NUM_OUTSTD);
    localparam int CW = PW + 1;
    localparam logic GNT_KNN = 1'b0;
    localparam logic GNT_FPS = 1'b1;

    typedef enum logic [1:0] {
        S_FREE     = 2'd0,
        S_LOCK_KNN = 2'd1,
        S_LOCK_FPS = 2'd2
    } lock_state_e;

    lock_state_e r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic          r_tag_mem [NUM_OUTSTD];
    logic          r_err;

    logic                  w_gnt, w_tie_gnt;
    logic                  w_full, w_any_vld, w_addr_vld, w_addr_rdy, w_ahs;
    logic                  w_nonempty, w_head, w_crd_rdy, w_dhs;
    logic [IDX_WIDTH-1:0]  w_sel_addr;
    logic [SRAM_WIDTH-1:0] w_crd;

`ifdef CRD_ARB_RR_EN
    logic r_last;
    assign w_tie_gnt = ~r_last;

    always_ff @(posedge clk) begin
        if (rst)        r_last <= GNT_FPS;
        else if (w_ahs) r_last <= w_gnt;
    end
`else
    assign w_tie_gnt = GNT_KNN;
`endif

    assign w_full     = (r_cnt == CW'(NUM_OUTSTD));
    assign w_any_vld  = bus.KNNARB_CrdAddrVld | bus.FPSARB_CrdAddrVld;
    assign w_addr_vld = w_any_vld & ~w_full;
    assign w_addr_rdy = bus.GLBARB_CrdAddrRdy & ~w_full;
    assign w_ahs      = w_addr_vld & bus.GLBARB_CrdAddrRdy;

    // A stalled grant stays locked until its address is accepted, so the GLB never sees it change.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_gnt       = GNT_KNN;
        w_state_nxt = r_state;
        case (r_state)
            S_LOCK_KNN: w_gnt = GNT_KNN;
            S_LOCK_FPS: w_gnt = GNT_FPS;
            default: begin
                if (bus.KNNARB_CrdAddrVld && bus.FPSARB_CrdAddrVld) w_gnt = w_tie_gnt;
                else if (bus.FPSARB_CrdAddrVld)                     w_gnt = GNT_FPS;
                else                                                w_gnt = GNT_KNN;
            end
        endcase
        if (w_ahs)
            w_state_nxt = S_FREE;
        else if (w_addr_vld)
            w_state_nxt = (w_gnt == GNT_FPS) ? S_LOCK_FPS : S_LOCK_KNN;
    end

    assign w_sel_addr            = (w_gnt == GNT_FPS) ? bus.FPSARB_CrdAddr : bus.KNNARB_CrdAddr;
    assign bus.ARBGLB_CrdAddr    = w_any_vld ? w_sel_addr : '0;
    assign bus.ARBGLB_CrdAddrVld = w_addr_vld;
    assign bus.ARBKNN_CrdAddrRdy = w_addr_rdy & (w_gnt == GNT_KNN) & bus.KNNARB_CrdAddrVld;
    assign bus.ARBFPS_CrdAddrRdy = w_addr_rdy & (w_gnt == GNT_FPS) & bus.FPSARB_CrdAddrVld;

    // Return steering: the oldest outstanding tag owns whatever the GLB hands back.
    assign w_nonempty        = (r_cnt != '0);
    assign w_head            = r_tag_mem[r_rd_ptr];
    assign w_crd             = bus.GLBARB_Crd;
    assign bus.ARBKNN_Crd    = w_crd;
    assign bus.ARBFPS_Crd    = w_crd;
    assign bus.ARBKNN_CrdVld = bus.GLBARB_CrdVld & w_nonempty & (w_head == GNT_KNN);
    assign bus.ARBFPS_CrdVld = bus.GLBARB_CrdVld & w_nonempty & (w_head == GNT_FPS);
    assign w_crd_rdy         = w_nonempty &
                               ((w_head == GNT_FPS) ? bus.FPSARB_CrdRdy : bus.KNNARB_CrdRdy);
    assign bus.ARBGLB_CrdRdy = w_crd_rdy;
    assign w_dhs             = bus.GLBARB_CrdVld & w_crd_rdy;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ahs) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_dhs) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_ahs, w_dhs})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (bus.GLBARB_CrdVld && !w_nonempty) r_err <= 1'b1;
        end
    end

    // NOTE: tag storage has no reset; entries are only read once the count marks them valid.
    always_ff @(posedge clk) begin
        if (w_ahs) r_tag_mem[r_wr_ptr] <= w_gnt;
    end

    assign ARBCCU_Idle = (r_cnt == '0) & ~w_any_vld;
    assign ARBCCU_Err  = r_err;
endmodule

// File: tb/tb_crd_rd_arb.sv
// Directed self-checking bench for crd_rd_arb (default NUM_OUTSTD=4).
// Inputs change on the falling edge; outputs are compared 1 ns later, well before the rising edge.
module tb_crd_rd_arb;
    logic clk = 1'b0;
    logic rst;
    logic idle, err;
    int   n_checks = 0;
    int   n_errors = 0;

    crd_rd_arb_if #(.IDX_WIDTH(10), .SRAM_WIDTH(256)) bus ();

    crd_rd_arb #(.IDX_WIDTH(10), .SRAM_WIDTH(256), .NUM_OUTSTD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ARBCCU_Idle (idle),
        .ARBCCU_Err  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.KNNARB_CrdAddr    = '0;
        bus.KNNARB_CrdAddrVld = 1'b0;
        bus.KNNARB_CrdRdy     = 1'b0;
        bus.FPSARB_CrdAddr    = '0;
        bus.FPSARB_CrdAddrVld = 1'b0;
        bus.FPSARB_CrdRdy     = 1'b0;
        bus.GLBARB_CrdAddrRdy = 1'b0;
        bus.GLBARB_Crd        = '0;
        bus.GLBARB_CrdVld     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic exp_seq [4];
        int   kn_left, fp_left;

        // Reset state
        do_reset();
        #1;
        check("rst_addr_vld", bus.ARBGLB_CrdAddrVld, 0);
        check("rst_addr",     bus.ARBGLB_CrdAddr, 0);
        check("rst_knn_rdy",  bus.ARBKNN_CrdAddrRdy, 0);
        check("rst_fps_rdy",  bus.ARBFPS_CrdAddrRdy, 0);
        check("rst_knn_cvld", bus.ARBKNN_CrdVld, 0);
        check("rst_fps_cvld", bus.ARBFPS_CrdVld, 0);
        check("rst_glb_crdy", bus.ARBGLB_CrdRdy, 0);
        check("rst_err",      err, 0);
        check("rst_idle",     idle, 1);
        @(negedge clk);

        // Single KNN read of 0x005, data two cycles later
        bus.KNNARB_CrdAddr    = 10'h005;
        bus.KNNARB_CrdAddrVld = 1'b1;
        bus.GLBARB_CrdAddrRdy = 1'b1;
        bus.KNNARB_CrdRdy     = 1'b1;
        #1;
        check("single_addr_vld", bus.ARBGLB_CrdAddrVld, 1);
        check("single_addr",     bus.ARBGLB_CrdAddr, 10'h005);
        check("single_knn_rdy",  bus.ARBKNN_CrdAddrRdy, 1);
        check("single_fps_rdy",  bus.ARBFPS_CrdAddrRdy, 0);
        @(negedge clk);
        bus.KNNARB_CrdAddrVld = 1'b0;
        #1;
        check("single_busy", idle, 0);
        @(negedge clk);
        bus.GLBARB_CrdVld = 1'b1;
        bus.GLBARB_Crd    = {8{32'hC0FFEE01}};
        #1;
        check("single_knn_cvld", bus.ARBKNN_CrdVld, 1);
        check("single_fps_cvld", bus.ARBFPS_CrdVld, 0);
        check("single_glb_crdy", bus.ARBGLB_CrdRdy, 1);
        check("single_knn_crd",  bus.ARBKNN_Crd, {8{32'hC0FFEE01}});
        @(negedge clk);
        bus.GLBARB_CrdVld = 1'b0;
        #1;
        check("single_idle", idle, 1);
        check("single_err",  err, 0);

        // Two reads each from KNN and FPS requested together; each return lands one cycle later
        do_reset();
`ifdef CRD_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
        kn_left = 2;
        fp_left = 2;
        bus.KNNARB_CrdAddr    = 10'h011;
        bus.FPSARB_CrdAddr    = 10'h022;
        bus.GLBARB_CrdAddrRdy = 1'b1;
        bus.KNNARB_CrdRdy     = 1'b1;
        bus.FPSARB_CrdRdy     = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            bus.KNNARB_CrdAddrVld = (kn_left > 0);
            bus.FPSARB_CrdAddrVld = (fp_left > 0);
            bus.GLBARB_CrdVld     = (i > 0);
            bus.GLBARB_Crd        = 256'(i + 32'hA0);
            #1;
            if (i < 4) begin
                check($sformatf("alt_addr_%0d", i), bus.ARBGLB_CrdAddr,
                      exp_seq[i] ? 10'h022 : 10'h011);
                check($sformatf("alt_rdy_%0d", i),
                      exp_seq[i] ? bus.ARBFPS_CrdAddrRdy : bus.ARBKNN_CrdAddrRdy, 1);
                if (exp_seq[i]) fp_left--;
                else            kn_left--;
            end
            if (i > 0) begin
                check($sformatf("alt_knn_cvld_%0d", i), bus.ARBKNN_CrdVld, !exp_seq[i-1]);
                check($sformatf("alt_fps_cvld_%0d", i), bus.ARBFPS_CrdVld, exp_seq[i-1]);
            end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        check("alt_idle", idle, 1);

        // Fill the tag FIFO with GLB never returning; one pop re-opens exactly one slot
        do_reset();
        bus.KNNARB_CrdAddr    = 10'h100;
        bus.KNNARB_CrdAddrVld = 1'b1;
        bus.GLBARB_CrdAddrRdy = 1'b1;
        bus.KNNARB_CrdRdy     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fill_rdy_%0d", i), bus.ARBKNN_CrdAddrRdy, 1);
            @(negedge clk);
        end
        #1;
        check("full_addr_vld", bus.ARBGLB_CrdAddrVld, 0);
        check("full_knn_rdy",  bus.ARBKNN_CrdAddrRdy, 0);
        @(negedge clk);
        bus.GLBARB_CrdVld = 1'b1;
        #1;
        check("full_pop_crdy",     bus.ARBGLB_CrdRdy, 1);
        check("full_pop_addr_vld", bus.ARBGLB_CrdAddrVld, 0);
        @(negedge clk);
        bus.GLBARB_CrdVld = 1'b0;
        #1;
        check("fifth_addr_vld", bus.ARBGLB_CrdAddrVld, 1);
        check("fifth_knn_rdy",  bus.ARBKNN_CrdAddrRdy, 1);
        @(negedge clk);
        #1;
        check("refull_addr_vld", bus.ARBGLB_CrdAddrVld, 0);
        bus.KNNARB_CrdAddrVld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.GLBARB_CrdVld = 1'b1;
            #1;
            check($sformatf("drain_knn_cvld_%0d", i), bus.ARBKNN_CrdVld, 1);
            @(negedge clk);
        end
        bus.GLBARB_CrdVld = 1'b0;
        #1;
        check("drain_idle", idle, 1);
        check("drain_err",  err, 0);

        // Lock: FPS stalled for 3 cycles keeps the grant while KNN is waiting
        do_reset();
        bus.FPSARB_CrdAddr    = 10'h02A;
        bus.KNNARB_CrdAddr    = 10'h015;
        bus.FPSARB_CrdAddrVld = 1'b1;
        #1;
        check("lock_first_addr", bus.ARBGLB_CrdAddr, 10'h02A);
        check("lock_first_rdy",  bus.ARBFPS_CrdAddrRdy, 0);
        @(negedge clk);
        bus.KNNARB_CrdAddrVld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("lock_hold_addr_%0d", i), bus.ARBGLB_CrdAddr, 10'h02A);
            check($sformatf("lock_hold_knn_rdy_%0d", i), bus.ARBKNN_CrdAddrRdy, 0);
            @(negedge clk);
        end
        bus.GLBARB_CrdAddrRdy = 1'b1;
        #1;
        check("lock_rel_fps_rdy", bus.ARBFPS_CrdAddrRdy, 1);
        check("lock_rel_knn_rdy", bus.ARBKNN_CrdAddrRdy, 0);
        check("lock_rel_addr",    bus.ARBGLB_CrdAddr, 10'h02A);
        @(negedge clk);
        bus.FPSARB_CrdAddrVld = 1'b0;
        #1;
        check("lock_next_knn_rdy", bus.ARBKNN_CrdAddrRdy, 1);
        check("lock_next_addr",    bus.ARBGLB_CrdAddr, 10'h015);
        @(negedge clk);
        bus.KNNARB_CrdAddrVld = 1'b0;
        bus.GLBARB_CrdAddrRdy = 1'b0;

        // Backpressure: head tag is FPS, FPS not ready, KNN ready
        bus.GLBARB_CrdVld = 1'b1;
        bus.GLBARB_Crd    = {4{64'h1234_5678_9ABC_DEF0}};
        bus.FPSARB_CrdRdy = 1'b0;
        bus.KNNARB_CrdRdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("bp_glb_crdy_%0d", i), bus.ARBGLB_CrdRdy, 0);
            check($sformatf("bp_fps_cvld_%0d", i), bus.ARBFPS_CrdVld, 1);
            check($sformatf("bp_knn_cvld_%0d", i), bus.ARBKNN_CrdVld, 0);
            @(negedge clk);
        end
        bus.FPSARB_CrdRdy = 1'b1;
        #1;
        check("bp_rel_crdy", bus.ARBGLB_CrdRdy, 1);
        check("bp_fps_crd",  bus.ARBFPS_Crd, {4{64'h1234_5678_9ABC_DEF0}});
        @(negedge clk);
        #1;
        check("bp_next_knn_cvld", bus.ARBKNN_CrdVld, 1);
        check("bp_next_fps_cvld", bus.ARBFPS_CrdVld, 0);
        @(negedge clk);
        bus.GLBARB_CrdVld = 1'b0;
        #1;
        check("bp_idle", idle, 1);
        check("bp_err",  err, 0);

        // Spurious GLB data with nothing in flight
        bus.GLBARB_CrdVld = 1'b1;
        #1;
        check("spur_crdy",     bus.ARBGLB_CrdRdy, 0);
        check("spur_knn_cvld", bus.ARBKNN_CrdVld, 0);
        check("spur_err_pre",  err, 0);
        @(negedge clk);
        bus.GLBARB_CrdVld = 1'b0;
        #1;
        check("spur_err_set", err, 1);
        @(negedge clk);
        #1;
        check("spur_err_sticky", err, 1);
        do_reset();
        #1;
        check("spur_err_clr", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
